ring_seq: RTL and testbench

RING_SEQ -- requirements
Module: ring_seq

---
 rtl/ring_seq.sv | 117 +++++++++++
 tb/tb_ring_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_seq.sv
// ring_seq: N-state circular sequencer with per-state advance conditions,
// selectable direction, priority load, and registered wrap/timeout pulses.
// Optional dwell timeout is compiled in with `define RING_SEQ_TIMEOUT_EN;
// without it the tmo output is tied low and a state holds until advanced.
`timescale 1ns/1ps

module ring_seq #(
  parameter int unsigned N   = 3,
  parameter int unsigned TMO = 8
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic [N-1:0]                           adv,
  input  logic                                   en,
  input  logic                                   dir,
  input  logic                                   load,
  input  logic [(($clog2(N) < 1) ? 1 : $clog2(N))-1:0] load_st,
  output logic [(($clog2(N) < 1) ? 1 : $clog2(N))-1:0] y,
  output logic [N-1:0]                           onehot,
  output logic                                   wrap,
  output logic                                   tmo
);

  localparam int unsigned W = ($clog2(N) < 1) ? 1 : $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  // Elaboration-time guard on the legal parameter ranges.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("ring_seq: N out of range 2..16");
  end
  if (TMO < 2 || TMO > 255) begin : g_bad_tmo
    $error("ring_seq: TMO out of range 2..255");
  end

  logic [W-1:0] y_q;
  logic         wrap_q;
  logic [W-1:0] step_st;
  logic         step_wraps;
  logic         load_ok;

`ifdef RING_SEQ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
  logic [CW-1:0] cnt;
  logic          tmo_q;
`endif

  assign load_ok = (32'(load_st) < N);

  // Neighbour state in the selected direction, and whether that step wraps.
  always_comb begin
    step_st    = '0;
    step_wraps = 1'b0;
    if (dir) begin
      step_wraps = (y_q == '0);
      step_st    = step_wraps ? LAST : (y_q - W'(1));
    end else begin
      step_wraps = (y_q == LAST);
      step_st    = step_wraps ? '0 : (y_q + W'(1));
    end
  end

  // Ring state, pulse registers and dwell counter; load beats advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      y_q    <= '0;
      wrap_q <= 1'b0;
`ifdef RING_SEQ_TIMEOUT_EN
      cnt    <= '0;
      tmo_q  <= 1'b0;
`endif
    end else begin
      wrap_q <= 1'b0;
`ifdef RING_SEQ_TIMEOUT_EN
      tmo_q  <= 1'b0;
`endif
      if (load) begin
        if (load_ok) begin
          y_q <= load_st;
        end
`ifdef RING_SEQ_TIMEOUT_EN
        cnt <= '0;
`endif
      end else if (en) begin
        if (adv[y_q]) begin
          y_q    <= step_st;
          wrap_q <= step_wraps;
`ifdef RING_SEQ_TIMEOUT_EN
          cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
          y_q    <= step_st;
          wrap_q <= step_wraps;
          tmo_q  <= 1'b1;
          cnt    <= '0;
        end else begin
          cnt    <= cnt + CW'(1);
`endif
        end
      end
    end
  end

  // One-hot view decoded straight from the state register.
  always_comb begin
    onehot      = '0;
    onehot[y_q] = 1'b1;
  end

  assign y    = y_q;
  assign wrap = wrap_q;
`ifdef RING_SEQ_TIMEOUT_EN
  assign tmo  = tmo_q;
`else
  assign tmo  = 1'b0;
`endif

endmodule

// File: tb/tb_ring_seq.sv
// tb_ring_seq: scoreboard bench for ring_seq (N=3, TMO=4). Expected outputs
// come from a modular-arithmetic ring model; timeout expectations follow
// whether RING_SEQ_TIMEOUT_EN is defined for the build.
`timescale 1ns/1ps

module tb_ring_seq;

  localparam int N   = 3;
  localparam int TMO = 4;
  localparam int W   = 2;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] adv = '0;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_st = '0;
  logic [W-1:0] y;
  logic [N-1:0] onehot;
  logic         wrap;
  logic         tmo;

  ring_seq #(.N(N), .TMO(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .adv     (adv),
    .en      (en),
    .dir     (dir),
    .load    (load),
    .load_st (load_st),
    .y       (y),
    .onehot  (onehot),
    .wrap    (wrap),
    .tmo     (tmo)
  );

  always #5 clock = ~clock;

  typedef struct {
    string        tag;
    int           y;
    logic [N-1:0] oh;
    bit           w;
    bit           t;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: current ring position and consecutive idle enabled cycles.
  int m_y    = 0;
  int m_idle = 0;

  task automatic check(input string tag, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, req);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared just after the edge.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, ".y"},      int'(y),      e.y);
      check({e.tag, ".onehot"}, int'(onehot), int'(e.oh));
      check({e.tag, ".wrap"},   int'(wrap),   int'(e.w));
      check({e.tag, ".tmo"},    int'(tmo),    int'(e.t));
    end
  end

  // Drive one cycle of inputs and push the model's post-edge prediction.
  task automatic step(input string tag, input logic [N-1:0] a, input bit e,
                      input bit d, input bit l, input logic [W-1:0] ls);
    exp_t x;
    bit   mv;
    bit   forced;
    int   nxt;
    @(negedge clock);
    adv = a; en = e; dir = d; load = l; load_st = ls;
    mv = 1'b0;
    forced = 1'b0;
    x.tag = tag;
    x.w = 1'b0;
    x.t = 1'b0;
    if (l) begin
      if (int'(ls) < N) m_y = int'(ls);
      m_idle = 0;
    end else if (e) begin
      if (a[m_y]) begin
        mv = 1'b1;
      end else begin
`ifdef RING_SEQ_TIMEOUT_EN
        m_idle++;
        if (m_idle == TMO) begin
          mv = 1'b1;
          forced = 1'b1;
        end
`endif
      end
      if (mv) begin
        nxt = d ? (m_y + N - 1) % N : (m_y + 1) % N;
        x.w = d ? (nxt > m_y) : (nxt < m_y);
        x.t = forced;
        m_y = nxt;
        m_idle = 0;
      end
    end
    x.y = m_y;
    x.oh = '0;
    x.oh[m_y] = 1'b1;
    sb.push_back(x);
  endtask

  // Reset asserted between edges; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    #2;
    en = 1'b0;
    load = 1'b0;
    reset_n = 1'b0;
    #1;
    check({tag, ".y"},      int'(y),      0);
    check({tag, ".onehot"}, int'(onehot), 1);
    check({tag, ".wrap"},   int'(wrap),   0);
    check({tag, ".tmo"},    int'(tmo),    0);
    m_y = 0;
    m_idle = 0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("reset.y",      int'(y),      0);
    check("reset.onehot", int'(onehot), 1);
    check("reset.wrap",   int'(wrap),   0);
    check("reset.tmo",    int'(tmo),    0);
    @(negedge clock);
    reset_n = 1'b1;

    // Forward cycle, then backward wrap from 0.
    step("fwd1", 3'b111, 1, 0, 0, 2'd0);
    step("fwd2", 3'b111, 1, 0, 0, 2'd0);
    step("fwd3", 3'b111, 1, 0, 0, 2'd0);
    step("bwd",  3'b001, 1, 1, 0, 2'd0);
    step("bwd_hold", 3'b111, 0, 0, 0, 2'd0);

    // Load priority over advance, and out-of-range load holding state.
    step("ld1",    3'b000, 0, 0, 1, 2'd1);
    step("ldpri",  3'b010, 1, 0, 1, 2'd0);
    step("ld1b",   3'b000, 1, 0, 1, 2'd1);
    step("ldbad",  3'b111, 1, 0, 1, 2'd3);
    step("nonsel", 3'b101, 1, 0, 0, 2'd0);

    // Enable gate.
    for (int i = 0; i < 5; i++) step("engate", 3'b111, 0, 1'($urandom), 0, 2'd0);

    // Dwell with no advance: forced steps only when timeout is compiled in.
    step("ld0", 3'b000, 0, 0, 1, 2'd0);
    for (int i = 0; i < 20; i++) step("dwell", 3'b000, 1, 0, 0, 2'd0);

    // Asynchronous reset while at state 2.
    step("ld2", 3'b000, 0, 0, 1, 2'd2);
    do_reset("areset");
    step("post_rst", 3'b111, 1, 0, 0, 2'd0);

    // Randomized traffic with periodic resets.
    for (int i = 0; i < 450; i++) begin
      if (i % 150 == 149) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             (($urandom % 3) == 0) ? N'($urandom) : N'(0),
             ($urandom % 4) != 0,
             1'($urandom),
             ($urandom % 8) == 0,
             W'($urandom % 4));
      end
    end

    @(negedge clock);
    @(negedge clock);
    check("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
